// File: rtl/vgc_irq_ctrl.sv
// vgc_irq_ctrl -- IIgs VGC interrupt controller.
//
// Watches the beam counters from video_top and produces three interrupt
// sources: vertical blank, per-line scanline (SHR only) and the one-second
// tick derived from counting VBLs. Status and enables are exposed through
// the $C023/$C032/$C041/$C046/$C047 softswitches, and one level IRQ goes
// to the CPU.
//
// Ports
//   clk_vid     in   pixel clock, all logic on the rising edge
//   reset       in   synchronous, active-high
//   H           in   [9:0] horizontal beam counter
//   V           in   [8:0] vertical beam counter (SHR line = V[8:1])
//   shrg_mode   in   super-hires enabled
//   scb_i       in   [7:0] SCB of the current SHR line, bit 6 = scanline IRQ
//   reg_addr    in   [7:0] low byte of the $C0xx address
//   reg_rd      in   one-cycle read strobe
//   reg_wr      in   one-cycle write strobe
//   reg_wdata   in   [7:0] write data
//   reg_rdata   out  [7:0] registered read data, held until the next read
//   vbl_pulse   out  one-cycle pulse per VBL event
//   scan_pulse  out  one-cycle pulse per scanline event
//   irq_o       out  level IRQ, registered one clock behind the pending flags
module vgc_irq_ctrl #(
  parameter int VBL_LINE    = 400,
  parameter int SCAN_IRQ_H  = 640,
  parameter int VBL_PER_SEC = 60
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic [9:0] H,
  input  logic [8:0] V,
  input  logic       shrg_mode,
  input  logic [7:0] scb_i,
  input  logic [7:0] reg_addr,
  input  logic       reg_rd,
  input  logic       reg_wr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       vbl_pulse,
  output logic       scan_pulse,
  output logic       irq_o
);

  localparam int         SEC_W   = $clog2(VBL_PER_SEC);
  localparam logic [8:0] VBL_V   = 9'(VBL_LINE);
  localparam logic [9:0] SCAN_H  = 10'(SCAN_IRQ_H);
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(VBL_PER_SEC - 1);

  localparam logic [7:0] A_VGCINT   = 8'h23;
  localparam logic [7:0] A_SCANINT  = 8'h32;
  localparam logic [7:0] A_INTEN    = 8'h41;
  localparam logic [7:0] A_DIAGTYPE = 8'h46;
  localparam logic [7:0] A_CLRVBL   = 8'h47;

  logic [9:0]       prev_h;
  logic [8:0]       prev_v;
  // prev_h/prev_v reset to 0, which would look like "before blank" to the
  // edge detectors. Holding events off until one real sample has been
  // captured keeps a reset inside blank from producing a spurious VBL.
  logic             prev_vld;
  logic [SEC_W-1:0] sec_cnt;
  logic             scan_en, sec_en;
  logic [4:0]       inten;
  logic             scan_pend, sec_pend, vbl_pend;

  logic       vbl_en;
  logic       vbl_evt, scan_evt, sec_evt;
  logic       irq_vgc;
  logic       wr_vgcint, wr_scanint, wr_inten, acc_clrvbl;
  logic [7:0] rd_mux;
  logic       unused_ok;

  assign vbl_en   = inten[3];

  assign vbl_evt  = prev_vld && (prev_v < VBL_V) && (V >= VBL_V);

  // Second line of each doubled pair only, so one event per SHR line.
  assign scan_evt = prev_vld && (H == SCAN_H) && (prev_h != H) && V[0] &&
                    (V < VBL_V) && shrg_mode && scb_i[6];

  assign sec_evt  = vbl_evt && (sec_cnt == SEC_MAX);

  assign irq_vgc  = (sec_pend & sec_en) | (scan_pend & scan_en);

  assign wr_vgcint  = reg_wr && (reg_addr == A_VGCINT);
  assign wr_scanint = reg_wr && (reg_addr == A_SCANINT);
  assign wr_inten   = reg_wr && (reg_addr == A_INTEN);
  assign acc_clrvbl = (reg_rd || reg_wr) && (reg_addr == A_CLRVBL);

  always_comb begin
    rd_mux = 8'h00;
    case (reg_addr)
      A_VGCINT:   rd_mux = {irq_vgc, sec_pend, scan_pend, 2'b00, sec_en, scan_en, 1'b0};
      A_INTEN:    rd_mux = {3'b000, inten};
      A_DIAGTYPE: rd_mux = {4'b0000, vbl_pend, 3'b000};
      default:    rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      prev_h     <= '0;
      prev_v     <= '0;
      prev_vld   <= 1'b0;
      sec_cnt    <= '0;
      scan_en    <= 1'b0;
      sec_en     <= 1'b0;
      inten      <= '0;
      scan_pend  <= 1'b0;
      sec_pend   <= 1'b0;
      vbl_pend   <= 1'b0;
      vbl_pulse  <= 1'b0;
      scan_pulse <= 1'b0;
      irq_o      <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      prev_h     <= H;
      prev_v     <= V;
      prev_vld   <= 1'b1;
      vbl_pulse  <= vbl_evt;
      scan_pulse <= scan_evt;

      if (vbl_evt)
        sec_cnt <= sec_evt ? '0 : sec_cnt + 1'b1;

      if (wr_vgcint) begin
        sec_en  <= reg_wdata[2];
        scan_en <= reg_wdata[1];
      end
      if (wr_inten)
        inten <= reg_wdata[4:0];

      // Set has priority over clear so an event landing on a clear is kept.
      if (scan_evt)
        scan_pend <= 1'b1;
      else if (wr_scanint && !reg_wdata[5])
        scan_pend <= 1'b0;

      if (sec_evt)
        sec_pend <= 1'b1;
      else if (wr_scanint && !reg_wdata[6])
        sec_pend <= 1'b0;

      if (vbl_evt)
        vbl_pend <= 1'b1;
      else if (acc_clrvbl)
        vbl_pend <= 1'b0;

      irq_o <= (scan_pend & scan_en) | (sec_pend & sec_en) | (vbl_pend & vbl_en);

      if (reg_rd)
        reg_rdata <= rd_mux;
    end
  end

  assign unused_ok = &{1'b0, scb_i[7], scb_i[5:0], reg_wdata[7]};

endmodule

// File: tb/tb_vgc_irq_ctrl.sv
module tb_vgc_irq_ctrl;

  logic       clk_vid = 1'b0;
  logic       reset;
  logic [9:0] H;
  logic [8:0] V;
  logic       shrg_mode;
  logic [7:0] scb_i;
  logic [7:0] reg_addr;
  logic       reg_rd;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       vbl_pulse;
  logic       scan_pulse;
  logic       irq_o;

  int n_vec = 0;
  int n_bad = 0;
  int pulses;

  vgc_irq_ctrl dut (
    .clk_vid    (clk_vid),
    .reset      (reset),
    .H          (H),
    .V          (V),
    .shrg_mode  (shrg_mode),
    .scb_i      (scb_i),
    .reg_addr   (reg_addr),
    .reg_rd     (reg_rd),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .vbl_pulse  (vbl_pulse),
    .scan_pulse (scan_pulse),
    .irq_o      (irq_o)
  );

  always #5 clk_vid = ~clk_vid;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_vid);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a);
    reg_addr = a;
    reg_rd   = 1'b1;
    tick();
    reg_rd   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    reg_read(a);
    check(tag, reg_rdata, exp);
  endtask

  // One VBL event: V crosses 399 -> 400.
  task automatic frame();
    V = 9'd399;
    tick();
    V = 9'd400;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; H = '0; V = '0; shrg_mode = 1'b0; scb_i = '0;
    reg_addr = '0; reg_rd = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
    tick();
    tick();
    check("rst_rdata", reg_rdata, 8'h00);
    check("rst_vbl_pulse", {7'b0, vbl_pulse}, 8'h00);
    check("rst_scan_pulse", {7'b0, scan_pulse}, 8'h00);
    check("rst_irq", {7'b0, irq_o}, 8'h00);
    reset = 1'b0;
    tick();

    // VBL path
    reg_write(8'h41, 8'h08);
    read_check("inten_rd", 8'h41, 8'h08);
    V = 9'd399;
    tick();
    V = 9'd400;
    tick();
    check("vbl_pulse_hi", {7'b0, vbl_pulse}, 8'h01);
    check("vbl_irq_not_yet", {7'b0, irq_o}, 8'h00);
    tick();
    check("vbl_pulse_lo", {7'b0, vbl_pulse}, 8'h00);
    check("vbl_irq_hi", {7'b0, irq_o}, 8'h01);
    read_check("diag_pend", 8'h46, 8'h08);
    reg_read(8'h47);
    tick();
    check("vbl_irq_clr", {7'b0, irq_o}, 8'h00);
    read_check("diag_clr", 8'h46, 8'h00);

    // Scanline path
    V = 9'd11; shrg_mode = 1'b1; scb_i = 8'h40; H = 10'd639;
    reg_write(8'h23, 8'h02);
    H = 10'd640;
    tick();
    check("scan_pulse_hi", {7'b0, scan_pulse}, 8'h01);
    tick();
    check("scan_pulse_lo", {7'b0, scan_pulse}, 8'h00);
    read_check("vgcint_scan", 8'h23, 8'hA2);
    check("scan_irq_hi", {7'b0, irq_o}, 8'h01);
    reg_write(8'h32, 8'h00);
    read_check("vgcint_scan_clr", 8'h23, 8'h02);
    tick();
    check("scan_irq_clr", {7'b0, irq_o}, 8'h00);

    // Qualifiers that must suppress the scanline event
    H = 10'd639; V = 9'd10;
    tick();
    H = 10'd640;
    tick();
    check("scan_even_line", {7'b0, scan_pulse}, 8'h00);
    H = 10'd639; V = 9'd11; scb_i = 8'h00;
    tick();
    H = 10'd640;
    tick();
    check("scan_no_scb", {7'b0, scan_pulse}, 8'h00);
    H = 10'd639; scb_i = 8'h40; shrg_mode = 1'b0;
    tick();
    H = 10'd640;
    tick();
    check("scan_no_shr", {7'b0, scan_pulse}, 8'h00);
    read_check("vgcint_none", 8'h23, 8'h02);

    // H held at the trigger column: only the arrival counts
    H = 10'd639; shrg_mode = 1'b1;
    tick();
    H = 10'd640;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (scan_pulse) pulses++;
    end
    check("scan_hold_once", 8'(pulses), 8'h01);
    reg_write(8'h32, 8'h00);
    H = 10'd0; shrg_mode = 1'b0; scb_i = 8'h00; V = 9'd0;

    // VBL set wins over a simultaneous $47 write
    V = 9'd399;
    tick();
    V = 9'd400; reg_addr = 8'h47; reg_wdata = 8'h00; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
    check("race_pulse", {7'b0, vbl_pulse}, 8'h01);
    read_check("race_pend_kept", 8'h46, 8'h08);
    reg_write(8'h47, 8'h00);
    read_check("race_then_clr", 8'h46, 8'h00);

    // One-second counter from a clean reset
    do_reset();
    V = 9'd0;
    tick();
    reg_write(8'h23, 8'h04);
    for (int i = 0; i < 59; i++) frame();
    read_check("sec_59", 8'h23, 8'h04);
    frame();
    read_check("sec_60", 8'h23, 8'hC4);
    tick();
    check("sec_irq", {7'b0, irq_o}, 8'h01);

    // Everything pending, then reset inside blank
    reg_write(8'h41, 8'h08);
    reg_write(8'h23, 8'h06);
    shrg_mode = 1'b1; scb_i = 8'h40; V = 9'd11; H = 10'd639;
    tick();
    H = 10'd640;
    tick();
    read_check("all_pend", 8'h23, 8'hE6);
    read_check("all_pend_vbl", 8'h46, 8'h08);
    H = 10'd0; shrg_mode = 1'b0; scb_i = 8'h00; V = 9'd450;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst2_irq", {7'b0, irq_o}, 8'h00);
    check("rst2_rdata", reg_rdata, 8'h00);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (vbl_pulse) pulses++;
    end
    check("rst2_no_spurious_vbl", 8'(pulses), 8'h00);
    check("rst2_irq_after", {7'b0, irq_o}, 8'h00);
    read_check("rst2_vgcint", 8'h23, 8'h00);
    read_check("rst2_inten", 8'h41, 8'h00);
    read_check("rst2_diag", 8'h46, 8'h00);
    read_check("rst2_scanint", 8'h32, 8'h00);
    read_check("other_addr", 8'h55, 8'h00);
    reg_write(8'h23, 8'h04);
    for (int i = 0; i < 59; i++) frame();
    read_check("rst2_sec_59", 8'h23, 8'h04);
    frame();
    read_check("rst2_sec_60", 8'h23, 8'hC4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
